board_mem_arbiter: RTL and testbench
====================================

Name: board_mem_arbiter

Overview:
Shares the single-port cell-state board BRAM among three requesters: VGA pixel fetcher (display), generation update engine (sim), and cursor editor driven by the debounced buttons (edit). Issues one memory command per cycle and routes read data back to its issuer after the fixed BRAM read latency. Sits between the three requesters and the board BRAM inside top_level.

Parameters:
ADDR_WIDTH, 16, board word address width
DATA_WIDTH, 16, cells per BRAM word (1 bit per cell)
READ_LATENCY, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..4
MAX_STARVE, 8, consecutive display-blocked cycles after which a pending sim/edit request overrides display; legal range 1..255

Ports:
clk_in  input  1  system clock (100 MHz domain)
rst_n_in  input  1  asynchronous active-low reset
disp_req_in  input  1  display read request
disp_addr_in  input  ADDR_WIDTH  display read address
disp_gnt_out  output  1  display request accepted this cycle
disp_rvalid_out  output  1  display read data valid
sim_req_in  input  1  sim request
sim_we_in  input  1  sim write enable (0 = read)
sim_addr_in  input  ADDR_WIDTH  sim address
sim_wdata_in  input  DATA_WIDTH  sim write data
sim_gnt_out  output  1  sim request accepted
sim_rvalid_out  output  1  sim read data valid
edit_req_in, edit_we_in, edit_addr_in, edit_wdata_in  input  1/1/ADDR_WIDTH/DATA_WIDTH  edit request, same meaning as sim
edit_gnt_out  output  1  edit request accepted
edit_rvalid_out  output  1  edit read data valid
rdata_out  output  DATA_WIDTH  registered copy of mem_rdata, shared by all requesters, qualified by the *_rvalid_out bits
mem_en_out  output  1  BRAM enable
mem_we_out  output  1  BRAM write enable
mem_addr_out  output  ADDR_WIDTH  BRAM address
mem_wdata_out  output  DATA_WIDTH  BRAM write data
mem_rdata_in  input  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (rst_n_in low, asynchronous): all *_rvalid_out 0, rdata_out 0, tag pipeline cleared, starve counter 0, rr_last = EDIT (so sim wins first tie). While in reset, all gnt outputs and mem_en_out/mem_we_out are forced 0.
- Grants are combinational from the current requests and registered state; exactly zero or one gnt is high per cycle; a request is accepted only in a cycle with its gnt high; requesters hold req/addr/data until granted.
- Priority: display first, unless starve_cnt == MAX_STARVE and sim or edit is pending, in which case the sim/edit winner takes the cycle and display is denied.
- Sim vs edit: round-robin. If both are pending, the one not equal to rr_last wins. rr_last is updated only when sim or edit is granted.
- starve_cnt: increments (saturating at MAX_STARVE) each cycle in which sim or edit is pending but display is granted. It clears to 0 in any cycle in which sim or edit is granted, or in which neither is pending.
- Memory command: on a grant, mem_en_out = 1 and mem_addr_out/mem_we_out/mem_wdata_out are taken from the winner in the same cycle. Display always has mem_we_out = 0. With no grant, mem_en_out = 0 and the other mem outputs are 0.
- Read return: each granted read pushes tag {valid, id} into a READ_LATENCY-deep shift register. At the tail, rdata_out <= mem_rdata_in and the matching *_rvalid_out pulses for 1 cycle.
- Total latency from the gnt cycle to the rvalid cycle is READ_LATENCY+1 cycles, with one result per cycle and full throughput on back-to-back reads.
- Writes push no tag and produce no rvalid.
- Reset mid-read: in-flight tags are discarded and no rvalid is issued for them after reset is released.

Decomposition:
- life_pkg holds:
  - typedef enum logic[1:0] {REQ_DISP, REQ_SIM, REQ_EDIT} req_id_t
  - NUM_REQ = 3
  - a board word-type typedef, shared with the sim engine and fetcher
- Sub-module rd_tag_pipe (parameters READ_LATENCY, width of req_id_t): a shift register of valid+id tags with asynchronous clear. The arbiter core instantiates it once.

Test Plan:
- Display only: disp_req constant, addresses 0..3 back-to-back -> disp_gnt high every cycle, mem_addr 0,1,2,3, and disp_rvalid high 3 cycles after each gnt with rdata matching the preloaded words.
- Sim and edit both requesting reads continuously, display idle, after reset -> grants alternate sim, edit, sim, edit; rvalids alternate in the same order, 3 cycles later.
- Display held high with sim_req held high, MAX_STARVE=8 -> display granted cycles 0..7, sim granted cycle 8, display again from cycle 9, and the counter restarts.
- Edit write (addr 0x0005, wdata 0xA5A5), then sim read of 0x0005 -> mem_we 1 only on the edit gnt cycle, no edit_rvalid, and sim_rvalid with rdata 0xA5A5.
- rst_n_in pulsed low 1 cycle after a sim read gnt -> gnt and mem_en drop immediately, and no sim_rvalid appears after release.
- Simultaneous display, sim and edit requests with starve_cnt 0 -> display granted and rr_last unchanged.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types for the Life board datapath: requester IDs and the board word.
package life_pkg;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_SIM  = 2'd1,
    REQ_EDIT = 2'd2
  } req_id_t;

  localparam int NUM_REQ      = 3;
  localparam int BOARD_WORD_W = 16;

  typedef logic [BOARD_WORD_W-1:0] board_word_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid+ID shift register that tracks reads in flight through the BRAM.
module rd_tag_pipe #(
  parameter int READ_LATENCY = 2,
  parameter int ID_W         = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            push_valid_in,
  input  logic [ID_W-1:0] push_id_in,
  output logic            tail_valid_out,
  output logic [ID_W-1:0] tail_id_out
);

  logic [READ_LATENCY-1:0]           vld_q, vld_d;
  logic [READ_LATENCY-1:0][ID_W-1:0] id_q, id_d;

  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = push_valid_in;
    id_d[0]  = push_id_in;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign tail_valid_out = vld_q[READ_LATENCY-1];
  assign tail_id_out    = id_q[READ_LATENCY-1];

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board BRAM arbiter: display priority with starvation override,
// sim/edit round-robin, and tagged routing of read data back to its issuer.
module board_mem_arbiter
  import life_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_STARVE   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  disp_req_in,
  input  logic [ADDR_WIDTH-1:0] disp_addr_in,
  output logic                  disp_gnt_out,
  output logic                  disp_rvalid_out,
  input  logic                  sim_req_in,
  input  logic                  sim_we_in,
  input  logic [ADDR_WIDTH-1:0] sim_addr_in,
  input  logic [DATA_WIDTH-1:0] sim_wdata_in,
  output logic                  sim_gnt_out,
  output logic                  sim_rvalid_out,
  input  logic                  edit_req_in,
  input  logic                  edit_we_in,
  input  logic [ADDR_WIDTH-1:0] edit_addr_in,
  input  logic [DATA_WIDTH-1:0] edit_wdata_in,
  output logic                  edit_gnt_out,
  output logic                  edit_rvalid_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  mem_en_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  localparam int ID_W  = $bits(req_id_t);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  req_id_t               rr_last_q, rr_last_d;
  logic                  disp_rvalid_q, disp_rvalid_d;
  logic                  sim_rvalid_q, sim_rvalid_d;
  logic                  edit_rvalid_q, edit_rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic            se_pend, se_pick_sim, override, se_gnt;
  logic            disp_gnt, sim_gnt, edit_gnt;
  logic            push_valid;
  logic [ID_W-1:0] push_id;
  logic            tail_valid;
  logic [ID_W-1:0] tail_id;

  always_comb begin
    se_pend     = sim_req_in | edit_req_in;
    se_pick_sim = sim_req_in & (~edit_req_in | (rr_last_q != REQ_SIM));
    override    = se_pend & (starve_cnt_q == STARVE_LIMIT);
    // Grants are gated by reset so nothing reaches the BRAM while held in reset.
    disp_gnt    = rst_n_in & disp_req_in & ~override;
    se_gnt      = rst_n_in & se_pend & (~disp_req_in | override);
    sim_gnt     = se_gnt & se_pick_sim;
    edit_gnt    = se_gnt & ~se_pick_sim;

    mem_en_out    = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    push_valid    = 1'b0;
    push_id       = REQ_DISP;
    if (disp_gnt) begin
      mem_en_out   = 1'b1;
      mem_addr_out = disp_addr_in;
      push_valid   = 1'b1;
      push_id      = REQ_DISP;
    end else if (sim_gnt) begin
      mem_en_out    = 1'b1;
      mem_we_out    = sim_we_in;
      mem_addr_out  = sim_addr_in;
      mem_wdata_out = sim_wdata_in;
      push_valid    = ~sim_we_in;
      push_id       = REQ_SIM;
    end else if (edit_gnt) begin
      mem_en_out    = 1'b1;
      mem_we_out    = edit_we_in;
      mem_addr_out  = edit_addr_in;
      mem_wdata_out = edit_wdata_in;
      push_valid    = ~edit_we_in;
      push_id       = REQ_EDIT;
    end

    rr_last_d = rr_last_q;
    if (sim_gnt)  rr_last_d = REQ_SIM;
    if (edit_gnt) rr_last_d = REQ_EDIT;

    starve_cnt_d = starve_cnt_q;
    if (se_gnt || !se_pend)                         starve_cnt_d = '0;
    else if (disp_gnt && starve_cnt_q < STARVE_LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;

    disp_rvalid_d = tail_valid && (tail_id == REQ_DISP);
    sim_rvalid_d  = tail_valid && (tail_id == REQ_SIM);
    edit_rvalid_d = tail_valid && (tail_id == REQ_EDIT);
    rdata_d       = tail_valid ? mem_rdata_in : rdata_q;
  end

  rd_tag_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .ID_W         (ID_W)
  ) u_rd_tag_pipe (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .push_valid_in  (push_valid),
    .push_id_in     (push_id),
    .tail_valid_out (tail_valid),
    .tail_id_out    (tail_id)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      starve_cnt_q  <= '0;
      rr_last_q     <= REQ_EDIT;
      disp_rvalid_q <= 1'b0;
      sim_rvalid_q  <= 1'b0;
      edit_rvalid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      rr_last_q     <= rr_last_d;
      disp_rvalid_q <= disp_rvalid_d;
      sim_rvalid_q  <= sim_rvalid_d;
      edit_rvalid_q <= edit_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign disp_gnt_out    = disp_gnt;
  assign sim_gnt_out     = sim_gnt;
  assign edit_gnt_out    = edit_gnt;
  assign disp_rvalid_out = disp_rvalid_q;
  assign sim_rvalid_out  = sim_rvalid_q;
  assign edit_rvalid_out = edit_rvalid_q;
  assign rdata_out       = rdata_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a 2-cycle-latency BRAM model.
module tb_board_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        disp_req_in;
  logic [15:0] disp_addr_in;
  logic        disp_gnt_out, disp_rvalid_out;
  logic        sim_req_in, sim_we_in;
  logic [15:0] sim_addr_in, sim_wdata_in;
  logic        sim_gnt_out, sim_rvalid_out;
  logic        edit_req_in, edit_we_in;
  logic [15:0] edit_addr_in, edit_wdata_in;
  logic        edit_gnt_out, edit_rvalid_out;
  logic [15:0] rdata_out;
  logic        mem_en_out, mem_we_out;
  logic [15:0] mem_addr_out, mem_wdata_out;
  logic [15:0] mem_rdata_in;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  board_mem_arbiter dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .disp_req_in     (disp_req_in),
    .disp_addr_in    (disp_addr_in),
    .disp_gnt_out    (disp_gnt_out),
    .disp_rvalid_out (disp_rvalid_out),
    .sim_req_in      (sim_req_in),
    .sim_we_in       (sim_we_in),
    .sim_addr_in     (sim_addr_in),
    .sim_wdata_in    (sim_wdata_in),
    .sim_gnt_out     (sim_gnt_out),
    .sim_rvalid_out  (sim_rvalid_out),
    .edit_req_in     (edit_req_in),
    .edit_we_in      (edit_we_in),
    .edit_addr_in    (edit_addr_in),
    .edit_wdata_in   (edit_wdata_in),
    .edit_gnt_out    (edit_gnt_out),
    .edit_rvalid_out (edit_rvalid_out),
    .rdata_out       (rdata_out),
    .mem_en_out      (mem_en_out),
    .mem_we_out      (mem_we_out),
    .mem_addr_out    (mem_addr_out),
    .mem_wdata_out   (mem_wdata_out),
    .mem_rdata_in    (mem_rdata_in)
  );

  function automatic logic [15:0] init_word(input int a);
    return 16'hB000 | 16'(a);
  endfunction

  // BRAM model: registered read plus one output stage gives 2-cycle latency.
  logic [15:0] bram [16];
  logic [15:0] written = '0;
  logic [15:0] rd_s1 = '0;
  logic [15:0] rd_s2 = '0;

  always @(posedge clk_in) begin
    if (mem_en_out) begin
      if (mem_we_out) begin
        bram[mem_addr_out[3:0]]    <= mem_wdata_out;
        written[mem_addr_out[3:0]] <= 1'b1;
      end
      rd_s1 <= written[mem_addr_out[3:0]] ? bram[mem_addr_out[3:0]]
                                          : init_word(int'(mem_addr_out[3:0]));
    end
    rd_s2 <= rd_s1;
  end
  assign mem_rdata_in = rd_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    disp_req_in = 0; disp_addr_in = 0;
    sim_req_in = 0; sim_we_in = 0; sim_addr_in = 0; sim_wdata_in = 0;
    edit_req_in = 0; edit_we_in = 0; edit_addr_in = 0; edit_wdata_in = 0;

    // Reset state, with a display request that must not be granted.
    @(negedge clk_in);
    disp_req_in = 1'b1;
    #1;
    chk("rst_disp_gnt", disp_gnt_out, 0);
    chk("rst_mem_en", mem_en_out, 0);
    chk("rst_disp_rvalid", disp_rvalid_out, 0);
    chk("rst_sim_rvalid", sim_rvalid_out, 0);
    chk("rst_edit_rvalid", edit_rvalid_out, 0);
    chk("rst_rdata", rdata_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    disp_req_in = 1'b0;

    // Display only, addresses 0..3 back-to-back.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      disp_req_in  = (k < 4);
      disp_addr_in = 16'(k);
      #1;
      if (k < 4) begin
        chk("disp_gnt", disp_gnt_out, 1);
        chk("disp_mem_addr", mem_addr_out, 32'(k));
        chk("disp_mem_we", mem_we_out, 0);
      end
      if (k >= 3 && k < 7) begin
        chk("disp_rvalid", disp_rvalid_out, 1);
        chk("disp_rdata", rdata_out, init_word(k - 3));
      end else begin
        chk("disp_rvalid_idle", disp_rvalid_out, 0);
      end
    end

    @(negedge clk_in); rst_n_in = 1'b0;
    @(negedge clk_in); rst_n_in = 1'b1;

    // Sim and edit reads both pending: alternate sim, edit, ...
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      sim_req_in  = (k < 8); sim_we_in  = 0; sim_addr_in  = 16'd8;
      edit_req_in = (k < 8); edit_we_in = 0; edit_addr_in = 16'd9;
      #1;
      if (k < 8) begin
        chk("rr_sim_gnt", sim_gnt_out, (k % 2 == 0));
        chk("rr_edit_gnt", edit_gnt_out, (k % 2 == 1));
        chk("rr_mem_addr", mem_addr_out, (k % 2 == 0) ? 8 : 9);
      end
      if (k >= 3 && k < 11) begin
        chk("rr_sim_rvalid", sim_rvalid_out, ((k - 3) % 2 == 0));
        chk("rr_edit_rvalid", edit_rvalid_out, ((k - 3) % 2 == 1));
        chk("rr_rdata", rdata_out, init_word(((k - 3) % 2 == 0) ? 8 : 9));
      end else begin
        chk("rr_sim_rvalid_idle", sim_rvalid_out, 0);
        chk("rr_edit_rvalid_idle", edit_rvalid_out, 0);
      end
    end

    // Starvation: display and sim held; sim takes cycles 8 and 17.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      disp_req_in = 1; disp_addr_in = 16'd3;
      sim_req_in = 1; sim_we_in = 0; sim_addr_in = 16'd7;
      #1;
      chk("starve_disp_gnt", disp_gnt_out, !(k == 8 || k == 17));
      chk("starve_sim_gnt", sim_gnt_out, (k == 8 || k == 17));
    end
    @(negedge clk_in);
    disp_req_in = 0; sim_req_in = 0;
    repeat (5) @(negedge clk_in);

    // Edit write 0x0005 <= 0xA5A5, then sim read of 0x0005.
    edit_req_in = 1; edit_we_in = 1; edit_addr_in = 16'h0005; edit_wdata_in = 16'hA5A5;
    #1;
    chk("wr_edit_gnt", edit_gnt_out, 1);
    chk("wr_mem_we", mem_we_out, 1);
    chk("wr_mem_addr", mem_addr_out, 32'h5);
    chk("wr_mem_wdata", mem_wdata_out, 32'hA5A5);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk_in);
      edit_req_in = 0; edit_we_in = 0;
      sim_req_in = (k == 1); sim_we_in = 0; sim_addr_in = 16'h0005; sim_wdata_in = 0;
      #1;
      if (k == 1) begin
        chk("rd_sim_gnt", sim_gnt_out, 1);
        chk("rd_mem_we", mem_we_out, 0);
      end
      chk("wr_no_edit_rvalid", edit_rvalid_out, 0);
      chk("rd_sim_rvalid", sim_rvalid_out, (k == 4));
      if (k == 4) chk("rd_rdata", rdata_out, 32'hA5A5);
    end

    // Reset one cycle after a sim read grant.
    @(negedge clk_in);
    sim_req_in = 1; sim_we_in = 0; sim_addr_in = 16'd6;
    #1;
    chk("rstmid_sim_gnt", sim_gnt_out, 1);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("rstmid_gnt_drop", sim_gnt_out, 0);
    chk("rstmid_mem_en", mem_en_out, 0);
    for (int k = 2; k < 7; k++) begin
      @(negedge clk_in);
      rst_n_in = 1'b1; sim_req_in = 0;
      #1;
      chk("rstmid_no_rvalid", sim_rvalid_out, 0);
    end

    // All three pending with starve 0: display wins, rr_last untouched.
    @(negedge clk_in);
    disp_req_in = 1; disp_addr_in = 16'd1;
    sim_req_in = 1; sim_we_in = 0; sim_addr_in = 16'd2;
    edit_req_in = 1; edit_we_in = 0; edit_addr_in = 16'd4;
    #1;
    chk("all3_disp_gnt", disp_gnt_out, 1);
    chk("all3_sim_gnt", sim_gnt_out, 0);
    chk("all3_edit_gnt", edit_gnt_out, 0);
    @(negedge clk_in); disp_req_in = 0; #1;
    chk("all3_then_sim", sim_gnt_out, 1);
    chk("all3_then_sim_edit", edit_gnt_out, 0);
    @(negedge clk_in); disp_req_in = 1; #1;
    chk("all3b_disp_gnt", disp_gnt_out, 1);
    chk("all3b_edit_gnt", edit_gnt_out, 0);
    @(negedge clk_in); disp_req_in = 0; #1;
    chk("all3b_then_edit", edit_gnt_out, 1);
    chk("all3b_then_edit_sim", sim_gnt_out, 0);

    @(negedge clk_in);
    disp_req_in = 0; sim_req_in = 0; edit_req_in = 0;
    repeat (4) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
